blake2b_msg_buf: RTL

Message-block responder for the BLAKE2b compression core.
- Accepts one 128-byte message block as sixteen 64-bit words over a valid/ready stream.
- Holds the block stable for the duration of a compression.
- Answers a G-function's two sigma lookups (round/column → message index) and two message-word fetches (index → word) combinationally.
- Sits between the host-side data path and the G/round logic. It is the responder end of the G-function's sigma-table and message-block request ports.

---
 rtl/blake2b_msg_buf.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/blake2b_msg_buf.sv
// BLAKE2b message-block buffer: 16x64-bit block store plus sigma/message responder.
// Define MSG_BUF_DOUBLE_EN for a two-bank ping-pong build; default is single bank.
module blake2b_msg_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [63:0] wr_data_i,
  input  logic        wr_last_i,
  output logic        blk_valid_o,
  input  logic        blk_release_i,
  output logic        err_o,
  input  logic [3:0]  sigma_row_0_i,
  input  logic [3:0]  sigma_row_1_i,
  input  logic [3:0]  sigma_column_0_i,
  input  logic [3:0]  sigma_column_1_i,
  output logic [3:0]  mindex_0_o,
  output logic [3:0]  mindex_1_o,
  input  logic [3:0]  mindex_0_i,
  input  logic [3:0]  mindex_1_i,
  output logic [63:0] m_0_o,
  output logic [63:0] m_1_o
);

`ifdef MSG_BUF_DOUBLE_EN
  localparam int AW = 5;
`else
  localparam int AW = 4;
`endif

  logic [63:0]   mem [2**AW];
  logic [3:0]    cnt_q;
  logic          rdy_q;
  logic          vld_q;
  logic          err_q;
  logic          acc;
  logic          last_beat;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr_0;
  logic [AW-1:0] raddr_1;

  assign acc       = wr_valid_i & rdy_q;
  assign last_beat = acc & (cnt_q == 4'd15);

  // Sigma row constant, column c at nibble c; rounds 10/11 reuse rows 0/1.
  function automatic logic [63:0] sigma_row(
    input logic [3:0] row
  );
    logic [63:0] r;
    case (row)
      4'd0, 4'd10: r = 64'hFEDCBA9876543210;
      4'd1, 4'd11: r = 64'h357B20C16DF984AE;
      4'd2:        r = 64'h491763EADF250C8B;
      4'd3:        r = 64'h8F04A562EBCD1397;
      4'd4:        r = 64'hD386CB1EFA427509;
      4'd5:        r = 64'h91EF57D438B0A6C2;
      4'd6:        r = 64'hB8293670A4DEF15C;
      4'd7:        r = 64'hA2684F05931CE7BD;
      4'd8:        r = 64'h5A417D2C803B9EF6;
      4'd9:        r = 64'h0DC3E9BF5167482A;
      default:     r = 64'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] sigma_lu(
    input logic [3:0] row,
    input logic [3:0] col
  );
    logic [63:0] r;
    r = sigma_row(row);
    return r[{col, 2'b00} +: 4];
  endfunction

  assign mindex_0_o = sigma_lu(sigma_row_0_i, sigma_column_0_i);
  assign mindex_1_o = sigma_lu(sigma_row_1_i, sigma_column_1_i);

`ifdef MSG_BUF_DOUBLE_EN
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] occ_q;
  logic [1:0] occ_n;
  logic       rel;

  assign rel   = blk_release_i & (occ_q != 2'd0);
  assign occ_n = occ_q + {1'b0, last_beat} - {1'b0, rel};

  assign waddr   = {wptr_q, cnt_q};
  assign raddr_0 = {rptr_q, mindex_0_i};
  assign raddr_1 = {rptr_q, mindex_1_i};

  // Ping-pong occupancy, bank pointers and registered handshakes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= 4'd0;
      occ_q  <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      if (acc) cnt_q <= cnt_q + 4'd1;
      occ_q  <= occ_n;
      wptr_q <= wptr_q ^ last_beat;
      rptr_q <= rptr_q ^ rel;
      rdy_q  <= (occ_n != 2'd2);
      vld_q  <= (occ_n != 2'd0);
    end
  end
`else
  typedef enum logic {FILL, FULL} state_t;
  state_t state_q;

  assign waddr   = cnt_q;
  assign raddr_0 = mindex_0_i;
  assign raddr_1 = mindex_1_i;

  // Fill/hold sequencing with registered handshakes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FILL;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          rdy_q <= 1'b1;
          if (acc) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= FULL;
              rdy_q   <= 1'b0;
              vld_q   <= 1'b1;
            end
          end
        end
        FULL: begin
          if (blk_release_i) begin
            state_q <= FILL;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
          end
        end
      endcase
    end
  end
`endif

  // Sticky framing error: last flag disagrees with beat position.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (acc && (wr_last_i != (cnt_q == 4'd15))) begin
      err_q <= 1'b1;
    end
  end

  // Block storage; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (acc) mem[waddr] <= wr_data_i;
  end

  assign wr_ready_o  = rdy_q;
  assign blk_valid_o = vld_q;
  assign err_o       = err_q;
  assign m_0_o       = vld_q ? mem[raddr_0] : 64'h0;
  assign m_1_o       = vld_q ? mem[raddr_1] : 64'h0;

endmodule
